instr_decode_stage: RTL and testbench

- Registered decode stage that sits in front of the ALU and drives its control inputs.
- Accepts a 32-bit ARM-subset instruction over a valid/ready handshake and evaluates its condition field against an internal NZCV flag register.
- Emits ALU control code, flag-write enable, register indices and immediate through a single-entry output register.
- The NZCV register is written back from the ALU's cpsr[31:28] result. Condition-failed instructions are squashed inside the stage.

---
 rtl/instr_decode_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Purpose : registered ARM-subset decode stage; evaluates condition codes against NZCV and drives ALU control.
// Latency : 1 cycle from accept to out_valid; condition-failed instructions are consumed and emit nothing.
// Backpr. : single-entry output register; in_ready = !out_valid || out_ready, outputs hold while stalled.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready/instr    instruction handshake and 32-bit instruction word
//   flush                      synchronous flush: drops the held entry, blocks capture this cycle
//   flag_we/flag_in            NZCV write-back from ALU cpsr[31:28] as {N,Z,C,V}
//   out_valid/out_ready        decoded-entry handshake
//   alu_ctl, cpsr_en           ALU operation code and flag-update enable
//   rn, rd, rm, imm            register indices and decoded immediate
//   illegal                    entry is undecodable (still emitted so downstream can trap)
//   nzcv                       current flag register
//   dec_count, squash_count    only with DECODE_STATS_EN: emitted / condition-squashed counts
//
// Optional feature macro: DECODE_STATS_EN

module instr_decode_stage #(
   parameter int CTL_W       = 11,
   parameter int ILLEGAL_CTL = 127
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic             flush,
   input  logic             flag_we,
   input  logic [3:0]       flag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CTL_W-1:0] alu_ctl,
   output logic             cpsr_en,
   output logic [3:0]       rn,
   output logic [3:0]       rd,
   output logic [3:0]       rm,
   output logic [31:0]      imm,
   output logic             illegal,
   output logic [3:0]       nzcv
`ifdef DECODE_STATS_EN
   ,
   output logic [15:0]      dec_count,
   output logic [15:0]      squash_count
`endif
);

   localparam logic [CTL_W-1:0] CTL_ADD  = CTL_W'(0);
   localparam logic [CTL_W-1:0] CTL_ADDI = CTL_W'(1);
   localparam logic [CTL_W-1:0] CTL_SUB  = CTL_W'(2);
   localparam logic [CTL_W-1:0] CTL_AND  = CTL_W'(3);
   localparam logic [CTL_W-1:0] CTL_ORR  = CTL_W'(4);
   localparam logic [CTL_W-1:0] CTL_EOR  = CTL_W'(5);
   localparam logic [CTL_W-1:0] CTL_MOV  = CTL_W'(6);
   localparam logic [CTL_W-1:0] CTL_MVN  = CTL_W'(7);
   localparam logic [CTL_W-1:0] CTL_CMP  = CTL_W'(8);
   localparam logic [CTL_W-1:0] CTL_TST  = CTL_W'(9);
   localparam logic [CTL_W-1:0] CTL_TEQ  = CTL_W'(10);
   localparam logic [CTL_W-1:0] CTL_BIC  = CTL_W'(11);
   localparam logic [CTL_W-1:0] CTL_B    = CTL_W'(31);
   localparam logic [CTL_W-1:0] CTL_BL   = CTL_W'(32);
   localparam logic [CTL_W-1:0] CTL_LDR  = CTL_W'(41);
   localparam logic [CTL_W-1:0] CTL_STR  = CTL_W'(42);
   localparam logic [CTL_W-1:0] CTL_ILL  = CTL_W'(ILLEGAL_CTL);

   // Condition check on {N,Z,C,V}.
   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cond)
         4'h0:    cond_ok = z;
         4'h1:    cond_ok = !z;
         4'h2:    cond_ok = c;
         4'h3:    cond_ok = !c;
         4'h4:    cond_ok = n;
         4'h5:    cond_ok = !n;
         4'h6:    cond_ok = v;
         4'h7:    cond_ok = !v;
         4'h8:    cond_ok = c && !z;
         4'h9:    cond_ok = !c || z;
         4'hA:    cond_ok = (n == v);
         4'hB:    cond_ok = (n != v);
         4'hC:    cond_ok = !z && (n == v);
         4'hD:    cond_ok = z || (n != v);
         4'hE:    cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   endfunction

   logic             accept;
   logic             cond_pass;
   logic             capture;
   logic [3:0]       eval_flags;

   logic [CTL_W-1:0] d_ctl;
   logic             d_cpsr;
   logic [3:0]       d_rn;
   logic [3:0]       d_rd;
   logic [3:0]       d_rm;
   logic [31:0]      d_imm;
   logic             d_ill;
   logic [31:0]      imm8_ext;
   logic [4:0]       rot_amt;

   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   // Forward a same-cycle flag write so a conditional instruction right behind a
   // flag-setting one sees the fresh flags.
   assign eval_flags = flag_we ? flag_in : nzcv;
   assign cond_pass  = cond_ok(instr[31:28], eval_flags);
   assign capture    = accept && cond_pass && !flush;

   assign imm8_ext   = {24'd0, instr[7:0]};
   assign rot_amt    = {instr[11:8], 1'b0};

   always_comb begin
      d_ctl  = CTL_ILL;
      d_cpsr = 1'b0;
      d_rn   = 4'd0;
      d_rd   = 4'd0;
      d_rm   = 4'd0;
      d_imm  = 32'd0;
      d_ill  = 1'b1;

      if (instr[27:26] == 2'b00) begin
         // Data processing.
         d_rn  = instr[19:16];
         d_rd  = instr[15:12];
         d_rm  = instr[3:0];
         d_ill = 1'b0;
         if (instr[25]) begin
            // Shift by 32 yields 0, so rot_amt == 0 leaves imm8 unchanged.
            d_imm = (imm8_ext >> rot_amt) | (imm8_ext << (6'd32 - {1'b0, rot_amt}));
         end
         case (instr[24:21])
            4'b0000: d_ctl = CTL_AND;
            4'b0001: d_ctl = CTL_EOR;
            4'b0010: d_ctl = CTL_SUB;
            4'b0100: d_ctl = instr[25] ? CTL_ADDI : CTL_ADD;
            4'b1000: d_ctl = CTL_TST;
            4'b1001: d_ctl = CTL_TEQ;
            4'b1010: d_ctl = CTL_CMP;
            4'b1100: d_ctl = CTL_ORR;
            4'b1101: d_ctl = CTL_MOV;
            4'b1110: d_ctl = CTL_BIC;
            4'b1111: d_ctl = CTL_MVN;
            default: begin
               d_ctl = CTL_ILL;
               d_ill = 1'b1;
            end
         endcase
         // Compare/test ops exist only to set flags, so they always update.
         if (!d_ill) begin
            d_cpsr = instr[20] || (instr[24:23] == 2'b10);
         end
      end else if (instr[27:26] == 2'b01) begin
         // Load / store with 12-bit unsigned offset.
         d_ctl = instr[20] ? CTL_LDR : CTL_STR;
         d_rn  = instr[19:16];
         d_rd  = instr[15:12];
         d_imm = {20'd0, instr[11:0]};
         d_ill = 1'b0;
      end else if (instr[27:25] == 3'b101) begin
         // Branch: word offset becomes a byte offset.
         d_ctl = instr[24] ? CTL_BL : CTL_B;
         d_rd  = instr[24] ? 4'd14 : 4'd0;
         d_imm = {{6{instr[23]}}, instr[23:0], 2'b00};
         d_ill = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         nzcv      <= 4'd0;
         alu_ctl   <= '0;
         cpsr_en   <= 1'b0;
         rn        <= 4'd0;
         rd        <= 4'd0;
         rm        <= 4'd0;
         imm       <= 32'd0;
         illegal   <= 1'b0;
      end else begin
         if (flag_we) begin
            nzcv <= flag_in;
         end

         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            // A squashed accept also retires the old entry, since in_ready
            // implies it was either empty or consumed this cycle.
            out_valid <= cond_pass;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // Payload only moves on capture, so it is stable while stalled.
         if (capture) begin
            alu_ctl <= d_ctl;
            cpsr_en <= d_cpsr;
            rn      <= d_rn;
            rd      <= d_rd;
            rm      <= d_rm;
            imm     <= d_imm;
            illegal <= d_ill;
         end
      end
   end

`ifdef DECODE_STATS_EN
   // Counters wrap naturally and are deliberately untouched by flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_count    <= 16'd0;
         squash_count <= 16'd0;
      end else begin
         if (capture) begin
            dec_count <= dec_count + 16'd1;
         end
         if (accept && !cond_pass && !flush) begin
            squash_count <= squash_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Purpose : directed, table-driven check of instr_decode_stage decode, conditions, handshake, flush, reset.
// Latency : expects entries one cycle after accept.
// Backpr. : exercises stall with out_ready=0 and release.

module tb_instr_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        flush;
   logic        flag_we;
   logic [3:0]  flag_in;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] alu_ctl;
   logic        cpsr_en;
   logic [3:0]  rn;
   logic [3:0]  rd;
   logic [3:0]  rm;
   logic [31:0] imm;
   logic        illegal;
   logic [3:0]  nzcv;
`ifdef DECODE_STATS_EN
   logic [15:0] dec_count;
   logic [15:0] squash_count;
`endif

   int total;
   int bad;

   instr_decode_stage #(.CTL_W(11), .ILLEGAL_CTL(127)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .instr        (instr),
      .flush        (flush),
      .flag_we      (flag_we),
      .flag_in      (flag_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .alu_ctl      (alu_ctl),
      .cpsr_en      (cpsr_en),
      .rn           (rn),
      .rd           (rd),
      .rm           (rm),
      .imm          (imm),
      .illegal      (illegal),
      .nzcv         (nzcv)
`ifdef DECODE_STATS_EN
      ,
      .dec_count    (dec_count),
      .squash_count (squash_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      logic [10:0] ctl;
      logic        cpsr;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [3:0]  rm;
      logic [31:0] imm;
      logic        ill;
      logic        chk_cpsr;
      logic        chk_imm;
      logic [2:0]  chk_regs;  // {rn, rd, rm}
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      in_valid = 1'b0;
      flag_we  = 1'b1;
      flag_in  = f;
      step();
      flag_we  = 1'b0;
   endtask

   task automatic cond_sweep(input logic [3:0] f, input logic [15:0] pass_mask);
      logic [31:0] w;
      set_flags(f);
      chk($sformatf("flags_%h", f), {28'd0, nzcv}, {28'd0, f});
      for (int c = 0; c < 16; c++) begin
         w        = 32'h0A000004;
         w[31:28] = c[3:0];
         instr    = w;
         in_valid = 1'b1;
         step();
         chk($sformatf("cond_f%h_c%0d", f, c), {31'd0, out_valid}, {31'd0, pass_mask[c]});
      end
      in_valid = 1'b0;
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;

      vecs[0]  = '{32'hE0821003, 11'd0,   1'b0, 4'd2, 4'd1,  4'd3, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[1]  = '{32'hE2821005, 11'd1,   1'b0, 4'd2, 4'd1,  4'd5, 32'h5,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[2]  = '{32'hE3A01CFF, 11'd6,   1'b0, 4'd0, 4'd1,  4'hF, 32'h0000FF00, 1'b0, 1'b1, 1'b1, 3'b111};
      vecs[3]  = '{32'hE1510002, 11'd8,   1'b1, 4'd1, 4'd0,  4'd2, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[4]  = '{32'hE0121003, 11'd3,   1'b1, 4'd2, 4'd1,  4'd3, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[5]  = '{32'hE0221003, 11'd5,   1'b0, 4'd2, 4'd1,  4'd3, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[6]  = '{32'hE0421003, 11'd2,   1'b0, 4'd2, 4'd1,  4'd3, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[7]  = '{32'hE1110002, 11'd9,   1'b1, 4'd1, 4'd0,  4'd2, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[8]  = '{32'hE1310002, 11'd10,  1'b1, 4'd1, 4'd0,  4'd2, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[9]  = '{32'hE1821003, 11'd4,   1'b0, 4'd2, 4'd1,  4'd3, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[10] = '{32'hE1C21003, 11'd11,  1'b0, 4'd2, 4'd1,  4'd3, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[11] = '{32'hE1E01003, 11'd7,   1'b0, 4'd0, 4'd1,  4'd3, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[12] = '{32'hE2821102, 11'd1,   1'b0, 4'd2, 4'd1,  4'd2, 32'h80000000, 1'b0, 1'b1, 1'b1, 3'b111};
      vecs[13] = '{32'hE1B01003, 11'd6,   1'b1, 4'd0, 4'd1,  4'd3, 32'h0,        1'b0, 1'b1, 1'b1, 3'b111};
      vecs[14] = '{32'hE0621003, 11'd127, 1'b0, 4'd0, 4'd0,  4'd0, 32'h0,        1'b1, 1'b0, 1'b0, 3'b000};
      vecs[15] = '{32'hE5912ABC, 11'd41,  1'b0, 4'd0, 4'd0,  4'd0, 32'h00000ABC, 1'b0, 1'b1, 1'b1, 3'b000};
      vecs[16] = '{32'hE5812123, 11'd42,  1'b0, 4'd0, 4'd0,  4'd0, 32'h00000123, 1'b0, 1'b1, 1'b1, 3'b000};
      vecs[17] = '{32'hEAFFFFFE, 11'd31,  1'b0, 4'd0, 4'd0,  4'd0, 32'hFFFFFFF8, 1'b0, 1'b1, 1'b1, 3'b000};
      vecs[18] = '{32'hEB000010, 11'd32,  1'b0, 4'd0, 4'd14, 4'd0, 32'h00000040, 1'b0, 1'b1, 1'b1, 3'b010};
      vecs[19] = '{32'hEC000000, 11'd127, 1'b0, 4'd0, 4'd0,  4'd0, 32'h0,        1'b1, 1'b1, 1'b0, 3'b000};
      vecs[20] = '{32'hE8000000, 11'd127, 1'b0, 4'd0, 4'd0,  4'd0, 32'h0,        1'b1, 1'b1, 1'b0, 3'b000};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      instr     = 32'd0;
      flush     = 1'b0;
      flag_we   = 1'b0;
      flag_in   = 4'd0;
      out_ready = 1'b1;
      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_nzcv",      {28'd0, nzcv},      32'd0);
      chk("rst_alu_ctl",   {21'd0, alu_ctl},   32'd0);
      chk("rst_cpsr_en",   {31'd0, cpsr_en},   32'd0);
      chk("rst_regs",      {20'd0, rn, rd, rm}, 32'd0);
      chk("rst_imm",       imm,                32'd0);
      chk("rst_illegal",   {31'd0, illegal},   32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
`ifdef DECODE_STATS_EN
      chk("rst_counts",    {dec_count, squash_count}, 32'd0);
`endif
      #10;
      rst_n = 1'b1;

      // Back-to-back table vectors, all condition AL.
      for (int i = 0; i < NVEC; i++) begin
         instr    = vecs[i].ins;
         in_valid = 1'b1;
         step();
         chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d_ctl", i), {21'd0, alu_ctl}, {21'd0, vecs[i].ctl});
         chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
         if (vecs[i].chk_cpsr)
            chk($sformatf("v%0d_cpsr_en", i), {31'd0, cpsr_en}, {31'd0, vecs[i].cpsr});
         if (vecs[i].chk_imm)
            chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
         if (vecs[i].chk_regs[2])
            chk($sformatf("v%0d_rn", i), {28'd0, rn}, {28'd0, vecs[i].rn});
         if (vecs[i].chk_regs[1])
            chk($sformatf("v%0d_rd", i), {28'd0, rd}, {28'd0, vecs[i].rd});
         if (vecs[i].chk_regs[0])
            chk($sformatf("v%0d_rm", i), {28'd0, rm}, {28'd0, vecs[i].rm});
      end
      in_valid = 1'b0;
      step();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
`ifdef DECODE_STATS_EN
      chk("dec_count_table", {16'd0, dec_count}, NVEC);
`endif

      // BEQ with Z=0 is squashed; same BEQ with forwarded Z=1 passes.
      instr    = 32'hE1510002;
      in_valid = 1'b1;
      step();
      chk("cmp_ctl",  {21'd0, alu_ctl}, 32'd8);
      chk("cmp_cpsr", {31'd0, cpsr_en}, 32'd1);
      instr = 32'h0A000004;
      step();
      chk("beq_squash_valid", {31'd0, out_valid}, 32'd0);
`ifdef DECODE_STATS_EN
      chk("squash_count", {16'd0, squash_count}, 32'd1);
`endif
      flag_we = 1'b1;
      flag_in = 4'b0100;
      step();
      flag_we  = 1'b0;
      in_valid = 1'b0;
      chk("beq_fwd_valid", {31'd0, out_valid}, 32'd1);
      chk("beq_fwd_ctl",   {21'd0, alu_ctl}, 32'd31);
      chk("beq_fwd_imm",   imm, 32'd16);
      chk("beq_fwd_nzcv",  {28'd0, nzcv}, 32'h4);
      step();

      // All 16 conditions against three flag patterns.
      cond_sweep(4'b1001, 16'h565A);
      cond_sweep(4'b0110, 16'h66A5);
      cond_sweep(4'b0010, 16'h55A6);
      set_flags(4'b0000);

      // Backpressure: entry held for 3 cycles while the next one waits.
      out_ready = 1'b0;
      instr     = 32'hE0821003;
      in_valid  = 1'b1;
      step();
      chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
      instr = 32'hE3A01CFF;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
         chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d_ctl", k), {21'd0, alu_ctl}, 32'd0);
         chk($sformatf("bp%0d_regs", k), {20'd0, rn, rd, rm}, 32'h213);
         chk($sformatf("bp%0d_imm", k), imm, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_next_ctl",   {21'd0, alu_ctl}, 32'd6);
      chk("bp_next_imm",   imm, 32'h0000FF00);
      step();
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);

      // Illegal entry, then flush with a pending capturable instruction.
      out_ready = 1'b0;
      instr     = 32'hEC000000;
      in_valid  = 1'b1;
      step();
      chk("ill_valid",   {31'd0, out_valid}, 32'd1);
      chk("ill_flag",    {31'd0, illegal}, 32'd1);
      chk("ill_ctl",     {21'd0, alu_ctl}, 32'd127);
      chk("ill_cpsr_en", {31'd0, cpsr_en}, 32'd0);
      out_ready = 1'b1;
      instr     = 32'hE0821003;
      flush     = 1'b1;
      flag_we   = 1'b1;
      flag_in   = 4'b1010;
      step();
      flush    = 1'b0;
      flag_we  = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_no_capture", {21'd0, alu_ctl}, 32'd127);
      chk("flush_nzcv", {28'd0, nzcv}, 32'hA);
      step();
      chk("post_flush_valid", {31'd0, out_valid}, 32'd0);

      // Async reset mid-cycle with a held entry and all flags set.
      out_ready = 1'b0;
      instr     = 32'hE0821003;
      in_valid  = 1'b1;
      flag_we   = 1'b1;
      flag_in   = 4'b1111;
      step();
      in_valid = 1'b0;
      flag_we  = 1'b0;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      chk("pre_rst_nzcv",  {28'd0, nzcv}, 32'hF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid",   {31'd0, out_valid}, 32'd0);
      chk("arst_nzcv",    {28'd0, nzcv}, 32'd0);
      chk("arst_regs",    {20'd0, rn, rd, rm}, 32'd0);
      chk("arst_ctl",     {21'd0, alu_ctl}, 32'd0);
      #3;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
